// File: rtl/swc_alloc_port_client.sv
// Requester-side engine for one allocator port: keeps one prefetched page ready
// and serialises buffered free / force-free / set-usecnt requests onto the port.
module swc_alloc_port_client #(
    parameter int unsigned g_page_addr_width = 10,
    parameter int unsigned g_usecnt_width    = 5,
    parameter int unsigned g_timeout_cycles  = 1023
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    output logic                         pg_valid_o,
    output logic [g_page_addr_width-1:0] pg_addr_o,
    input  logic                         pg_take_i,
    input  logic                         free_req_i,
    input  logic [g_page_addr_width-1:0] free_pgaddr_i,
    output logic                         free_busy_o,
    input  logic                         ffree_req_i,
    input  logic [g_page_addr_width-1:0] ffree_pgaddr_i,
    output logic                         ffree_busy_o,
    input  logic                         usecnt_req_i,
    input  logic [g_page_addr_width-1:0] usecnt_pgaddr_i,
    input  logic [g_usecnt_width-1:0]    usecnt_val_i,
    output logic                         usecnt_busy_o,
    output logic                         alloc_o,
    output logic                         free_o,
    output logic                         force_free_o,
    output logic                         set_usecnt_o,
    output logic [g_page_addr_width-1:0] pgaddr_free_o,
    output logic [g_page_addr_width-1:0] pgaddr_force_free_o,
    output logic [g_page_addr_width-1:0] pgaddr_usecnt_o,
    output logic [g_usecnt_width-1:0]    usecnt_o,
    input  logic                         done_i,
    input  logic [g_page_addr_width-1:0] pgaddr_alloc_i,
    input  logic                         nomem_i,
    output logic                         timeout_o
);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StReq  = 1'b1;

    localparam int unsigned     CntW   = $clog2(g_timeout_cycles + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(g_timeout_cycles);

    logic [0:0]                   state_q;
    logic                         alloc_q, free_q, ffree_q, usecnt_q;
    logic                         pg_valid_q;
    logic [g_page_addr_width-1:0] pg_addr_q;
    logic                         free_busy_q, ffree_busy_q, usecnt_busy_q;
    logic [g_page_addr_width-1:0] free_addr_q, ffree_addr_q, usecnt_addr_q;
    logic [g_usecnt_width-1:0]    usecnt_val_q;
    logic [CntW-1:0]              cnt_q;
    logic [CntW-1:0]              cnt_inc;
    logic                         timeout_q;

    logic sel_ffree, sel_free, sel_usecnt, sel_alloc, sel_any;
    logic req_done;

    assign req_done = (state_q == StReq) && done_i;
    assign cnt_inc  = cnt_q + CntW'(1);
    assign sel_any  = sel_ffree | sel_free | sel_usecnt | sel_alloc;

    // Fixed priority: force_free > free > set_usecnt > alloc (alloc gated by nomem).
    always_comb begin
        sel_ffree  = 1'b0;
        sel_free   = 1'b0;
        sel_usecnt = 1'b0;
        sel_alloc  = 1'b0;
        if (state_q == StIdle) begin
            if (ffree_busy_q)                  sel_ffree  = 1'b1;
            else if (free_busy_q)              sel_free   = 1'b1;
            else if (usecnt_busy_q)            sel_usecnt = 1'b1;
            else if (!pg_valid_q && !nomem_i)  sel_alloc  = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            alloc_q       <= 1'b0;
            free_q        <= 1'b0;
            ffree_q       <= 1'b0;
            usecnt_q      <= 1'b0;
            pg_valid_q    <= 1'b0;
            pg_addr_q     <= '0;
            free_busy_q   <= 1'b0;
            ffree_busy_q  <= 1'b0;
            usecnt_busy_q <= 1'b0;
            free_addr_q   <= '0;
            ffree_addr_q  <= '0;
            usecnt_addr_q <= '0;
            usecnt_val_q  <= '0;
            cnt_q         <= '0;
            timeout_q     <= 1'b0;
        end else begin
            if (state_q == StIdle) begin
                if (sel_any) begin
                    state_q  <= StReq;
                    ffree_q  <= sel_ffree;
                    free_q   <= sel_free;
                    usecnt_q <= sel_usecnt;
                    alloc_q  <= sel_alloc;
                    cnt_q    <= '0;
                end
            end else if (done_i) begin
                state_q  <= StIdle;
                ffree_q  <= 1'b0;
                free_q   <= 1'b0;
                usecnt_q <= 1'b0;
                alloc_q  <= 1'b0;
            end else begin
                // Saturating counter; the request itself is never aborted.
                if (cnt_q != CntMax) cnt_q <= cnt_inc;
                if (cnt_inc == CntMax) timeout_q <= 1'b1;
            end

            if (ffree_busy_q) begin
                if (req_done && ffree_q) ffree_busy_q <= 1'b0;
            end else if (ffree_req_i) begin
                ffree_busy_q <= 1'b1;
                ffree_addr_q <= ffree_pgaddr_i;
            end

            if (free_busy_q) begin
                if (req_done && free_q) free_busy_q <= 1'b0;
            end else if (free_req_i) begin
                free_busy_q <= 1'b1;
                free_addr_q <= free_pgaddr_i;
            end

            if (usecnt_busy_q) begin
                if (req_done && usecnt_q) usecnt_busy_q <= 1'b0;
            end else if (usecnt_req_i) begin
                usecnt_busy_q <= 1'b1;
                usecnt_addr_q <= usecnt_pgaddr_i;
                usecnt_val_q  <= usecnt_val_i;
            end

            if (req_done && alloc_q) begin
                pg_valid_q <= 1'b1;
                pg_addr_q  <= pgaddr_alloc_i;
            end else if (pg_take_i && pg_valid_q) begin
                pg_valid_q <= 1'b0;
            end
        end
    end

    assign pg_valid_o          = pg_valid_q;
    assign pg_addr_o           = pg_addr_q;
    assign free_busy_o         = free_busy_q;
    assign ffree_busy_o        = ffree_busy_q;
    assign usecnt_busy_o       = usecnt_busy_q;
    assign alloc_o             = alloc_q;
    assign free_o              = free_q;
    assign force_free_o        = ffree_q;
    assign set_usecnt_o        = usecnt_q;
    assign pgaddr_free_o       = free_addr_q;
    assign pgaddr_force_free_o = ffree_addr_q;
    assign pgaddr_usecnt_o     = usecnt_addr_q;
    assign usecnt_o            = usecnt_val_q;
    assign timeout_o           = timeout_q;

endmodule

// File: tb/tb_swc_alloc_port_client.sv
// Scoreboard bench for swc_alloc_port_client: expected allocator operations are
// queued as stimulus is driven and compared as the DUT raises each strobe.
module tb_swc_alloc_port_client;

    localparam int AW = 10;
    localparam int UW = 5;
    localparam int KNone = 0, KAlloc = 1, KFree = 2, KFfree = 3, KUsecnt = 4, KMulti = 7;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          pg_valid_o;
    logic [AW-1:0] pg_addr_o;
    logic          pg_take_i = 1'b0;
    logic          free_req_i = 1'b0;
    logic [AW-1:0] free_pgaddr_i = '0;
    logic          free_busy_o;
    logic          ffree_req_i = 1'b0;
    logic [AW-1:0] ffree_pgaddr_i = '0;
    logic          ffree_busy_o;
    logic          usecnt_req_i = 1'b0;
    logic [AW-1:0] usecnt_pgaddr_i = '0;
    logic [UW-1:0] usecnt_val_i = '0;
    logic          usecnt_busy_o;
    logic          alloc_o, free_o, force_free_o, set_usecnt_o;
    logic [AW-1:0] pgaddr_free_o, pgaddr_force_free_o, pgaddr_usecnt_o;
    logic [UW-1:0] usecnt_o;
    logic          done_i = 1'b0;
    logic [AW-1:0] pgaddr_alloc_i = '0;
    logic          nomem_i = 1'b0;
    logic          timeout_o;

    typedef struct {
        int            kind;
        logic [AW-1:0] addr;
        logic [UW-1:0] val;
    } op_t;

    op_t sbq[$];
    int  n_checks = 0;
    int  n_fail = 0;

    always #5 clk = ~clk;

    swc_alloc_port_client #(
        .g_page_addr_width(AW),
        .g_usecnt_width   (UW),
        .g_timeout_cycles (8)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .pg_valid_o         (pg_valid_o),
        .pg_addr_o          (pg_addr_o),
        .pg_take_i          (pg_take_i),
        .free_req_i         (free_req_i),
        .free_pgaddr_i      (free_pgaddr_i),
        .free_busy_o        (free_busy_o),
        .ffree_req_i        (ffree_req_i),
        .ffree_pgaddr_i     (ffree_pgaddr_i),
        .ffree_busy_o       (ffree_busy_o),
        .usecnt_req_i       (usecnt_req_i),
        .usecnt_pgaddr_i    (usecnt_pgaddr_i),
        .usecnt_val_i       (usecnt_val_i),
        .usecnt_busy_o      (usecnt_busy_o),
        .alloc_o            (alloc_o),
        .free_o             (free_o),
        .force_free_o       (force_free_o),
        .set_usecnt_o       (set_usecnt_o),
        .pgaddr_free_o      (pgaddr_free_o),
        .pgaddr_force_free_o(pgaddr_force_free_o),
        .pgaddr_usecnt_o    (pgaddr_usecnt_o),
        .usecnt_o           (usecnt_o),
        .done_i             (done_i),
        .pgaddr_alloc_i     (pgaddr_alloc_i),
        .nomem_i            (nomem_i),
        .timeout_o          (timeout_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int strobe_kind();
        int n;
        n = int'(alloc_o) + int'(free_o) + int'(force_free_o) + int'(set_usecnt_o);
        if (n > 1) return KMulti;
        if (alloc_o) return KAlloc;
        if (free_o) return KFree;
        if (force_free_o) return KFfree;
        if (set_usecnt_o) return KUsecnt;
        return KNone;
    endfunction

    // Allocator responder: waits (bounded) for a strobe, holds done off for lat-1
    // cycles, then completes. held=1 only if the strobe stayed put and then dropped.
    task automatic serve(input int lat, input logic [AW-1:0] palloc, output op_t obs,
                         output bit held);
        int k;
        obs.kind = KNone;
        obs.addr = '0;
        obs.val  = '0;
        held     = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (strobe_kind() != KNone) break;
            tick();
        end
        k = strobe_kind();
        if (k == KNone) return;
        obs.kind = k;
        if (k == KFree) obs.addr = pgaddr_free_o;
        if (k == KFfree) obs.addr = pgaddr_force_free_o;
        if (k == KUsecnt) begin
            obs.addr = pgaddr_usecnt_o;
            obs.val  = usecnt_o;
        end
        held = 1'b1;
        for (int j = 1; j < lat; j++) begin
            tick();
            if (strobe_kind() != k) held = 1'b0;
        end
        done_i         = 1'b1;
        pgaddr_alloc_i = palloc;
        tick();
        done_i         = 1'b0;
        pgaddr_alloc_i = '0;
        if (strobe_kind() != KNone) held = 1'b0;
    endtask

    task automatic push_op(input int kind, input logic [AW-1:0] addr, input logic [UW-1:0] val);
        op_t e;
        e.kind = kind;
        e.addr = addr;
        e.val  = val;
        sbq.push_back(e);
    endtask

    task automatic test_reset();
        logic [63:0] outs;
        rst_i = 1'b1;
        tick();
        tick();
        outs = {pg_valid_o, pg_addr_o, free_busy_o, ffree_busy_o, usecnt_busy_o, alloc_o, free_o,
                force_free_o, set_usecnt_o, pgaddr_free_o, pgaddr_force_free_o, pgaddr_usecnt_o,
                usecnt_o, timeout_o};
        n_checks++;
        if (outs !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, want 0", outs);
        end
    endtask

    task automatic test_first_alloc();
        op_t obs, e;
        bit  held;
        rst_i = 1'b0;
        push_op(KAlloc, '0, '0);
        tick();
        n_checks++;
        if (alloc_o !== 1'b1) begin
            n_fail++;
            $display("FAIL first_alloc_latency: alloc_o=%b, want 1", alloc_o);
        end
        serve(4, 10'h155, obs, held);
        e = sbq.pop_front();
        n_checks++;
        if (obs.kind !== e.kind || held !== 1'b1) begin
            n_fail++;
            $display("FAIL first_alloc_op: kind=%0d held=%b, want kind=%0d held=1", obs.kind, held,
                     e.kind);
        end
        n_checks++;
        if (pg_valid_o !== 1'b1 || pg_addr_o !== 10'h155) begin
            n_fail++;
            $display("FAIL first_alloc_page: valid=%b addr=%h, want 1/155", pg_valid_o, pg_addr_o);
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (strobe_kind() !== KNone) begin
                n_fail++;
                $display("FAIL idle_no_alloc: strobe kind=%0d, want 0", strobe_kind());
            end
            tick();
        end
    endtask

    task automatic test_take_latency();
        op_t obs, e;
        bit  held;
        pg_take_i = 1'b1;
        tick();
        pg_take_i = 1'b0;
        n_checks++;
        if (pg_valid_o !== 1'b0 || alloc_o !== 1'b0) begin
            n_fail++;
            $display("FAIL take_edge1: valid=%b alloc=%b, want 0/0", pg_valid_o, alloc_o);
        end
        push_op(KAlloc, '0, '0);
        tick();
        n_checks++;
        if (alloc_o !== 1'b1) begin
            n_fail++;
            $display("FAIL take_edge2: alloc_o=%b, want 1", alloc_o);
        end
        serve(2, 10'h0AB, obs, held);
        e = sbq.pop_front();
        n_checks++;
        if (obs.kind !== e.kind || held !== 1'b1 || pg_addr_o !== 10'h0AB) begin
            n_fail++;
            $display("FAIL take_alloc: kind=%0d held=%b page=%h, want %0d/1/0ab", obs.kind, held,
                     pg_addr_o, e.kind);
        end
    endtask

    task automatic test_priority();
        op_t obs, e;
        bit  held;
        pg_take_i       = 1'b1;
        ffree_req_i     = 1'b1;
        ffree_pgaddr_i  = 10'h010;
        free_req_i      = 1'b1;
        free_pgaddr_i   = 10'h020;
        usecnt_req_i    = 1'b1;
        usecnt_pgaddr_i = 10'h030;
        usecnt_val_i    = 5'd3;
        push_op(KFfree, 10'h010, '0);
        push_op(KFree, 10'h020, '0);
        push_op(KUsecnt, 10'h030, 5'd3);
        push_op(KAlloc, '0, '0);
        tick();
        {pg_take_i, ffree_req_i, free_req_i, usecnt_req_i} = 4'b0;
        n_checks++;
        if ({ffree_busy_o, free_busy_o, usecnt_busy_o, pg_valid_o} !== 4'b1110) begin
            n_fail++;
            $display("FAIL prio_capture: busy/valid=%b, want 1110",
                     {ffree_busy_o, free_busy_o, usecnt_busy_o, pg_valid_o});
        end
        for (int n = 0; n < 4; n++) begin
            serve(1 + n, 10'h2C3, obs, held);
            e = sbq.pop_front();
            n_checks++;
            if (obs.kind !== e.kind || obs.addr !== e.addr || obs.val !== e.val || !held) begin
                n_fail++;
                $display("FAIL prio_op%0d: kind=%0d addr=%h val=%0d held=%b, want %0d/%h/%0d/1",
                         n, obs.kind, obs.addr, obs.val, held, e.kind, e.addr, e.val);
            end
            n_checks++;
            if ({ffree_busy_o, free_busy_o, usecnt_busy_o} !== (3'b011 >> n)) begin
                n_fail++;
                $display("FAIL prio_busy%0d: busy=%b, want %b", n,
                         {ffree_busy_o, free_busy_o, usecnt_busy_o}, 3'b011 >> n);
            end
        end
        n_checks++;
        if (pg_valid_o !== 1'b1 || pg_addr_o !== 10'h2C3) begin
            n_fail++;
            $display("FAIL prio_page: valid=%b addr=%h, want 1/2c3", pg_valid_o, pg_addr_o);
        end
    endtask

    task automatic test_nomem();
        op_t obs, e;
        bit  held;
        nomem_i   = 1'b1;
        pg_take_i = 1'b1;
        tick();
        pg_take_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (strobe_kind() !== KNone) begin
                n_fail++;
                $display("FAIL nomem_hold: strobe kind=%0d, want 0", strobe_kind());
            end
            tick();
        end
        free_req_i    = 1'b1;
        free_pgaddr_i = 10'h3FF;
        push_op(KFree, 10'h3FF, '0);
        tick();
        free_req_i = 1'b0;
        serve(2, '0, obs, held);
        e = sbq.pop_front();
        n_checks++;
        if (obs.kind !== e.kind || obs.addr !== e.addr || !held) begin
            n_fail++;
            $display("FAIL nomem_free: kind=%0d addr=%h held=%b, want %0d/%h/1", obs.kind, obs.addr,
                     held, e.kind, e.addr);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (alloc_o !== 1'b0) begin
                n_fail++;
                $display("FAIL nomem_hold2: alloc_o=%b, want 0", alloc_o);
            end
            tick();
        end
        nomem_i = 1'b0;
        push_op(KAlloc, '0, '0);
        tick();
        n_checks++;
        if (alloc_o !== 1'b1) begin
            n_fail++;
            $display("FAIL nomem_release: alloc_o=%b, want 1", alloc_o);
        end
        serve(3, 10'h1E1, obs, held);
        e = sbq.pop_front();
        n_checks++;
        if (obs.kind !== e.kind || !held || pg_addr_o !== 10'h1E1) begin
            n_fail++;
            $display("FAIL nomem_alloc: kind=%0d held=%b page=%h, want %0d/1/1e1", obs.kind, held,
                     pg_addr_o, e.kind);
        end
    endtask

    task automatic test_busy_drop();
        op_t obs, e;
        bit  held;
        free_req_i    = 1'b1;
        free_pgaddr_i = 10'h111;
        push_op(KFree, 10'h111, '0);
        tick();
        free_pgaddr_i = 10'h222;
        tick();
        free_req_i = 1'b0;
        serve(2, '0, obs, held);
        e = sbq.pop_front();
        n_checks++;
        if (obs.kind !== e.kind || obs.addr !== e.addr || !held) begin
            n_fail++;
            $display("FAIL busy_drop_op: kind=%0d addr=%h held=%b, want %0d/%h/1", obs.kind,
                     obs.addr, held, e.kind, e.addr);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (strobe_kind() !== KNone || free_busy_o !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_drop_idle: strobe=%0d busy=%b, want 0/0", strobe_kind(),
                         free_busy_o);
            end
            tick();
        end
        done_i         = 1'b1;
        pgaddr_alloc_i = 10'h000;
        tick();
        done_i = 1'b0;
        n_checks++;
        if (pg_valid_o !== 1'b1 || pg_addr_o !== 10'h1E1 || strobe_kind() !== KNone) begin
            n_fail++;
            $display("FAIL spurious_done: valid=%b page=%h strobe=%0d, want 1/1e1/0", pg_valid_o,
                     pg_addr_o, strobe_kind());
        end
    endtask

    task automatic test_timeout();
        op_t obs, e;
        int  waited;
        free_req_i    = 1'b1;
        free_pgaddr_i = 10'h0F0;
        push_op(KFree, 10'h0F0, '0);
        tick();
        free_req_i = 1'b0;
        waited     = 0;
        while (free_o !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        obs.addr = pgaddr_free_o;
        e        = sbq.pop_front();
        n_checks++;
        if (free_o !== 1'b1 || obs.addr !== e.addr) begin
            n_fail++;
            $display("FAIL timeout_strobe: free_o=%b addr=%h, want 1/%h", free_o, obs.addr, e.addr);
        end
        for (int k = 1; k <= 8; k++) begin
            n_checks++;
            if (timeout_o !== 1'b0 || free_o !== 1'b1) begin
                n_fail++;
                $display("FAIL timeout_early%0d: timeout=%b free=%b, want 0/1", k, timeout_o, free_o);
            end
            tick();
        end
        n_checks++;
        if (timeout_o !== 1'b1 || free_o !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_set: timeout=%b free=%b, want 1/1", timeout_o, free_o);
        end
        tick();
        tick();
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        n_checks++;
        if (timeout_o !== 1'b1 || free_o !== 1'b0 || free_busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_sticky: timeout=%b free=%b busy=%b, want 1/0/0", timeout_o,
                     free_o, free_busy_o);
        end
    endtask

    task automatic test_reset_mid_req();
        op_t obs, e;
        bit  held;
        int  waited;
        usecnt_req_i    = 1'b1;
        usecnt_pgaddr_i = 10'h2AA;
        usecnt_val_i    = 5'd7;
        tick();
        usecnt_req_i = 1'b0;
        waited       = 0;
        while (set_usecnt_o !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        n_checks++;
        if (set_usecnt_o !== 1'b1 || pgaddr_usecnt_o !== 10'h2AA || usecnt_o !== 5'd7) begin
            n_fail++;
            $display("FAIL rst_mid_strobe: strobe=%b addr=%h val=%0d, want 1/2aa/7", set_usecnt_o,
                     pgaddr_usecnt_o, usecnt_o);
        end
        tick();
        rst_i = 1'b1;
        tick();
        n_checks++;
        if ({alloc_o, free_o, force_free_o, set_usecnt_o, free_busy_o, ffree_busy_o,
             usecnt_busy_o, pg_valid_o, timeout_o} !== 9'b0) begin
            n_fail++;
            $display("FAIL rst_mid_clear: strobes/busy/valid/timeout=%b, want 0",
                     {alloc_o, free_o, force_free_o, set_usecnt_o, free_busy_o, ffree_busy_o,
                      usecnt_busy_o, pg_valid_o, timeout_o});
        end
        rst_i = 1'b0;
        push_op(KAlloc, '0, '0);
        serve(2, 10'h077, obs, held);
        e = sbq.pop_front();
        n_checks++;
        if (obs.kind !== e.kind || !held || pg_addr_o !== 10'h077) begin
            n_fail++;
            $display("FAIL rst_mid_alloc: kind=%0d held=%b page=%h, want %0d/1/077", obs.kind,
                     held, pg_addr_o, e.kind);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (strobe_kind() !== KNone) begin
                n_fail++;
                $display("FAIL rst_mid_idle: strobe kind=%0d, want 0", strobe_kind());
            end
            tick();
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_first_alloc();
        test_take_latency();
        test_priority();
        test_nomem();
        test_busy_drop();
        test_timeout();
        test_reset_mid_req();
        n_checks++;
        if (sbq.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: %0d entries left, want 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
